// File: rtl/dbus_ctrl_pkg.sv
// Shared types for the memory-stage data-bus sequencer: access kinds, FSM
// states, bus size codes and the alignment rule.
package dbus_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LBU,
    MEM_LH,
    MEM_LHU,
    MEM_LW,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } dbus_state_t;

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;

  // Halfwords need an even address, words a 4-byte-aligned one.
  function automatic logic is_misaligned(input mem_t t, input logic [1:0] a);
    case (t)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return a != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_ctrl_store_align.sv
// Combinational mapping of an access to bus size, byte strobes and
// lane-replicated store data; also used by the uncached path.
module store_align
  import dbus_ctrl_pkg::*;
(
  input  mem_t        type_i,
  input  logic [1:0]  addr_i,
  input  word_t       wdata_i,
  output logic [1:0]  size_o,
  output logic [3:0]  strobe_o,
  output word_t       data_o
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    size_o   = MSIZE1;
    strobe_o = 4'b0000;
    data_o   = '0;
    case (type_i)
      MEM_LB, MEM_LBU: size_o = MSIZE1;
      MEM_LH, MEM_LHU: size_o = MSIZE2;
      MEM_LW:          size_o = MSIZE4;
      MEM_SB: begin
        size_o   = MSIZE1;
        strobe_o = 4'b0001 << addr_i;
        data_o   = {4{wdata_i[7:0]}};
      end
      MEM_SH: begin
        size_o   = MSIZE2;
        strobe_o = addr_i[1] ? 4'b1100 : 4'b0011;
        data_o   = {2{wdata_i[15:0]}};
      end
      MEM_SW: begin
        size_o   = MSIZE4;
        strobe_o = 4'b1111;
        data_o   = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_ctrl.sv
// Memory-stage data-bus sequencer: issues one load/store over the
// valid/addr_ok/data_ok handshake, stalls the stage and returns extended load data.
module dbus_ctrl
  import dbus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  mem_t        req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        advance,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  dbus_state_t state_q;
  mem_t        type_q;
  logic [31:0] addr_q;
  word_t       wdata_q;
  logic        kill_q;
  word_t       rdata_q;
  word_t       rdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        issuable;
  logic        killed;

  assign misalign = is_misaligned(req_type, req_addr[1:0]);
  assign issuable = req_valid && (req_type != MEM_NONE) && !misalign;
  assign killed   = kill_q || flush;

  assign stall = !killed &&
                 ((state_q == ST_REQ) || (state_q == ST_WAIT) ||
                  ((state_q == ST_IDLE) && issuable));

  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;
  assign dreq_valid = (state_q == ST_REQ);
  assign dreq_addr  = {addr_q[31:2], 2'b00};

  // Request fields come from the captured copy so they stay stable while the
  // stage's inputs move on.
  store_align u_store_align (
    .type_i   (type_q),
    .addr_i   (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .size_o   (dreq_size),
    .strobe_o (dreq_strobe),
    .data_o   (dreq_data)
  );

  always_comb begin
    byte_sel = dresp_data[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? dresp_data[31:16] : dresp_data[15:0];
    rdata_d  = '0;
    case (type_q)
      MEM_LB:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: rdata_d = {24'h0, byte_sel};
      MEM_LH:  rdata_d = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: rdata_d = {16'h0, half_sel};
      MEM_LW:  rdata_d = dresp_data;
      default: rdata_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; a later
  // assignment in the same cycle overrides an earlier one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= MEM_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      kill_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issuable && !flush) begin
            state_q <= ST_REQ;
            type_q  <= req_type;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            kill_q  <= 1'b0;
          end
        end
        ST_REQ: begin
          // The bus forbids withdrawing a request, so a flush only marks it.
          if (flush) kill_q <= 1'b1;
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              if (killed) begin
                state_q <= ST_IDLE;
                kill_q  <= 1'b0;
              end else begin
                state_q <= ST_DONE;
                rdata_q <= rdata_d;
              end
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush) kill_q <= 1'b1;
          if (dresp_data_ok) begin
            if (killed) begin
              state_q <= ST_IDLE;
              kill_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              rdata_q <= rdata_d;
            end
          end
        end
        ST_DONE: begin
          if (flush || advance) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: each step drives inputs just after the rising
// edge and checks outputs before the next one.
module tb_dbus_ctrl;
  import dbus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  mem_t        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        advance;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  int checks   = 0;
  int failures = 0;
  int nstall;
  logic rv_seen;

  dbus_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_type      (req_type),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .advance       (advance),
    .flush         (flush),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .misalign      (misalign),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Accept, complete with both oks in the first REQ cycle, check in DONE, advance.
  task automatic do_load(input mem_t t, input logic [31:0] a, input logic [31:0] bus,
                         input logic [31:0] exp, input string tag);
    next(); req_valid = 1'b1; req_type = t; req_addr = a; #1;
    check({tag, "_stall_accept"}, {31'b0, stall}, 32'd1);
    next(); req_valid = 1'b0; req_type = MEM_NONE;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = bus; #1;
    check({tag, "_dreq_addr"}, dreq_addr, {a[31:2], 2'b00});
    next(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0; advance = 1'b1; #1;
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_rdata"}, resp_rdata, exp);
    next(); advance = 1'b0; #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; req_wdata = '0;
    advance = 1'b0; flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_dreq_valid", {31'b0, dreq_valid}, 32'd0);
    check("rst_dreq_addr", dreq_addr, 32'h0);
    check("rst_dreq_strobe", {28'b0, dreq_strobe}, 32'h0);
    reset = 1'b0;

    // LB at 0x1003, minimum latency, byte 3 of 0x80FF_0000 sign-extended.
    next(); req_valid = 1'b1; req_type = MEM_LB; req_addr = 32'h1003; #1;
    check("lb_stall_c0", {31'b0, stall}, 32'd1);
    check("lb_misalign", {31'b0, misalign}, 32'd0);
    check("lb_dreq_valid_c0", {31'b0, dreq_valid}, 32'd0);
    next(); req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h80FF_0000; #1;
    check("lb_dreq_valid_c1", {31'b0, dreq_valid}, 32'd1);
    check("lb_dreq_addr", dreq_addr, 32'h1000);
    check("lb_dreq_size", {30'b0, dreq_size}, 32'd0);
    check("lb_dreq_strobe", {28'b0, dreq_strobe}, 32'h0);
    check("lb_stall_c1", {31'b0, stall}, 32'd1);
    next(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; advance = 1'b1; #1;
    check("lb_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    check("lb_stall_c2", {31'b0, stall}, 32'd0);
    check("lb_dreq_valid_c2", {31'b0, dreq_valid}, 32'd0);
    next(); advance = 1'b0; #1;
    check("lb_idle_resp_valid", {31'b0, resp_valid}, 32'd0);

    // SH at 0x2002, addr_ok on the third REQ cycle, data_ok two cycles later.
    nstall = 0;
    next(); req_valid = 1'b1; req_type = MEM_SH; req_addr = 32'h2002; req_wdata = 32'h1234_ABCD; #1;
    nstall += int'(stall);
    next(); req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; req_wdata = '0; #1;
    nstall += int'(stall);
    check("sh_dreq_valid", {31'b0, dreq_valid}, 32'd1);
    check("sh_dreq_addr", dreq_addr, 32'h2000);
    check("sh_dreq_size", {30'b0, dreq_size}, 32'd1);
    check("sh_dreq_strobe", {28'b0, dreq_strobe}, 32'hC);
    check("sh_dreq_data", dreq_data, 32'hABCD_ABCD);
    next(); #1;
    nstall += int'(stall);
    next(); dresp_addr_ok = 1'b1; #1;
    nstall += int'(stall);
    check("sh_dreq_data_c3", dreq_data, 32'hABCD_ABCD);
    next(); dresp_addr_ok = 1'b0; #1;
    nstall += int'(stall);
    check("sh_dreq_valid_wait", {31'b0, dreq_valid}, 32'd0);
    next(); dresp_data_ok = 1'b1; dresp_data = 32'hFFFF_FFFF; #1;
    nstall += int'(stall);
    next(); dresp_data_ok = 1'b0; dresp_data = '0; advance = 1'b1; #1;
    nstall += int'(stall);
    check("sh_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("sh_rdata_store", resp_rdata, 32'h0);
    check("sh_stall_cycles", nstall, 32'd6);
    next(); advance = 1'b0; #1;

    // Misaligned requests issue nothing.
    req_valid = 1'b1; req_type = MEM_LW; req_addr = 32'h3001; #1;
    check("lw_misalign", {31'b0, misalign}, 32'd1);
    check("lw_mis_stall", {31'b0, stall}, 32'd0);
    next(); #1;
    check("lw_mis_dreq_valid", {31'b0, dreq_valid}, 32'd0);
    req_valid = 1'b0;
    req_type = MEM_SW; req_addr = 32'h3002; #1;
    check("sw_misalign", {31'b0, misalign}, 32'd1);
    req_type = MEM_LHU; req_addr = 32'h3001; #1;
    check("lhu_misalign", {31'b0, misalign}, 32'd1);
    req_type = MEM_LH; req_addr = 32'h3002; #1;
    check("lh_aligned", {31'b0, misalign}, 32'd0);
    req_type = MEM_NONE; req_addr = '0;

    // LHU at 0x4002 flushed in the first REQ cycle: drains, no response.
    rv_seen = 1'b0;
    next(); req_valid = 1'b1; req_type = MEM_LHU; req_addr = 32'h4002; #1;
    check("fl_stall_c0", {31'b0, stall}, 32'd1);
    next(); req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; flush = 1'b1; #1;
    check("fl_dreq_valid_c1", {31'b0, dreq_valid}, 32'd1);
    check("fl_stall_c1", {31'b0, stall}, 32'd0);
    check("fl_dreq_size", {30'b0, dreq_size}, 32'd1);
    rv_seen |= resp_valid;
    next(); flush = 1'b0; #1;
    check("fl_dreq_valid_c2", {31'b0, dreq_valid}, 32'd1);
    check("fl_stall_c2", {31'b0, stall}, 32'd0);
    rv_seen |= resp_valid;
    next(); dresp_addr_ok = 1'b1; #1;
    check("fl_dreq_valid_c3", {31'b0, dreq_valid}, 32'd1);
    rv_seen |= resp_valid;
    next(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1; dresp_data = 32'hBEEF_0000; #1;
    check("fl_dreq_valid_wait", {31'b0, dreq_valid}, 32'd0);
    check("fl_stall_wait", {31'b0, stall}, 32'd0);
    rv_seen |= resp_valid;
    // Back in IDLE: resp_valid stays low and a new SB is accepted at once.
    next(); dresp_data_ok = 1'b0; dresp_data = '0;
    req_valid = 1'b1; req_type = MEM_SB; req_addr = 32'h6001; req_wdata = 32'h0000_005A; #1;
    rv_seen |= resp_valid;
    check("fl_resp_never", {31'b0, rv_seen}, 32'd0);
    check("sb_stall_accept", {31'b0, stall}, 32'd1);
    next(); req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; req_wdata = '0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; #1;
    check("sb_dreq_addr", dreq_addr, 32'h6000);
    check("sb_dreq_strobe", {28'b0, dreq_strobe}, 32'h2);
    check("sb_dreq_data", dreq_data, 32'h5A5A_5A5A);
    next(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b1; #1;
    check("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
    next(); flush = 1'b0; #1;
    check("sb_flush_done_idle", {31'b0, resp_valid}, 32'd0);

    // Reset while in WAIT, then an LBU with a held DONE.
    next(); req_valid = 1'b1; req_type = MEM_LW; req_addr = 32'h5004; req_wdata = 32'h1111_2222; #1;
    next(); req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; dresp_addr_ok = 1'b1; #1;
    check("rw_dreq_addr", dreq_addr, 32'h5004);
    next(); dresp_addr_ok = 1'b0; reset = 1'b1; #1;
    check("rw_in_wait", {31'b0, dreq_valid}, 32'd0);
    next(); reset = 1'b0; #1;
    check("rw_stall", {31'b0, stall}, 32'd0);
    check("rw_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rw_dreq_valid", {31'b0, dreq_valid}, 32'd0);
    check("rw_dreq_addr0", dreq_addr, 32'h0);
    check("rw_dreq_size", {30'b0, dreq_size}, 32'd0);
    check("rw_dreq_data", dreq_data, 32'h0);
    check("rw_rdata", resp_rdata, 32'h0);
    next(); req_valid = 1'b1; req_type = MEM_LBU; req_addr = 32'h5000; #1;
    check("lbu_stall", {31'b0, stall}, 32'd1);
    next(); req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h0000_00F0; #1;
    check("lbu_dreq_addr", dreq_addr, 32'h5000);
    next(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h1234_5678;
    req_valid = 1'b1; req_type = MEM_LB; req_addr = 32'h8000; #1;
    for (int i = 0; i < 3; i++) begin
      check("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, 32'h0000_00F0);
      check("hold_dreq_valid", {31'b0, dreq_valid}, 32'd0);
      check("hold_stall", {31'b0, stall}, 32'd0);
      if (i < 2) next();
    end
    req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; advance = 1'b1;
    next(); advance = 1'b0; #1;
    check("hold_released", {31'b0, resp_valid}, 32'd0);
    check("hold_no_issue", {31'b0, dreq_valid}, 32'd0);

    // Extension variants.
    do_load(MEM_LH,  32'h7002, 32'h8001_1234, 32'hFFFF_8001, "lh_hi");
    do_load(MEM_LHU, 32'h7000, 32'h1234_9876, 32'h0000_9876, "lhu_lo");
    do_load(MEM_LBU, 32'h1001, 32'h0000_8000, 32'h0000_0080, "lbu_b1");
    do_load(MEM_LB,  32'h1002, 32'h007F_0000, 32'h0000_007F, "lb_pos");
    do_load(MEM_LW,  32'h9000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
